// File: rtl/imem_icache.sv
// Direct-mapped read-only instruction cache between the fetch stage and the
// instruction-side memory port; misses refill a whole line word by word.
module imem_icache #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned LINES          = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic            flush_i,
  output logic            ack_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned WB    = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = XLEN - IDX_W - WB - 2;
  localparam int unsigned NWORD = LINES * WORDS_PER_LINE;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [XLEN-1:0]    data_q [NWORD];
  logic               flush_pend_q;
  logic [WB-1:0]      cnt_q;
  logic [TAG_W-1:0]   tag_l_q;
  logic [IDX_W-1:0]   idx_l_q;

  logic [IDX_W-1:0]   a_idx_c;
  logic [TAG_W-1:0]   a_tag_c;
  logic [WB-1:0]      a_word_c;
  logic               hit_c;
  logic               fire_c;
  logic               last_c;
  logic [WB-1:0]      cnt_nxt_c;
  logic               unused_addr_bits;

  assign a_idx_c          = addr_i[WB+2 +: IDX_W];
  assign a_tag_c          = addr_i[XLEN-1 -: TAG_W];
  assign a_word_c         = addr_i[2 +: WB];
  assign unused_addr_bits = ^addr_i[1:0];
  assign hit_c            = valid_q[a_idx_c] && (tag_q[a_idx_c] == a_tag_c);
  assign fire_c           = (state_q == REFILL) && mem_ack_i;
  assign last_c           = (cnt_q == WB'(WORDS_PER_LINE - 1));
  assign cnt_nxt_c        = cnt_q + WB'(1);

  // Data and tag storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rst_n && fire_c) begin
      data_q[{idx_l_q, cnt_q}] <= mem_rdata_i;
      if (last_c) tag_q[idx_l_q] <= tag_l_q;
    end
  end

  // Lookup / refill control with registered responses and memory requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      tag_l_q      <= '0;
      idx_l_q      <= '0;
      ack_o        <= 1'b0;
      rdata_o      <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            valid_q <= '0;
          end else if (req_i) begin
            if (hit_c) begin
              ack_o   <= 1'b1;
              rdata_o <= data_q[{a_idx_c, a_word_c}];
            end else begin
              tag_l_q    <= a_tag_c;
              idx_l_q    <= a_idx_c;
              cnt_q      <= '0;
              mem_req_o  <= 1'b1;
              mem_addr_o <= {a_tag_c, a_idx_c, WB'(0), 2'b00};
              state_q    <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (mem_ack_i) begin
            if (last_c) begin
              // A flush seen at any point of the fill leaves the new line invalid too.
              if (flush_pend_q || flush_i) valid_q <= '0;
              else                          valid_q[idx_l_q] <= 1'b1;
              flush_pend_q <= 1'b0;
              cnt_q        <= '0;
              mem_req_o    <= 1'b0;
              state_q      <= IDLE;
            end else begin
              cnt_q      <= cnt_nxt_c;
              mem_addr_o <= {tag_l_q, idx_l_q, cnt_nxt_c, 2'b00};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_icache.sv
// Directed bench for imem_icache: miss/hit timing, eviction, wait states,
// flushes, redirect during refill and reset during refill.
module tb_imem_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int wcnt   = 0;

  imem_icache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .flush_i    (flush_i),
    .ack_o      (ack_o),
    .rdata_o    (rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Memory model: word n of the space returns 0x1000+n, after wait_n wait cycles.
  assign mem_ack_i   = (mem_req_o === 1'b1) && (wcnt == wait_n);
  assign mem_rdata_i = 32'h1000 + 32'(mem_addr_o[11:2]);

  always @(posedge clk) begin
    if (mem_req_o === 1'b1 && !mem_ack_i) wcnt <= wcnt + 1;
    else                                  wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; addr_i = '0; flush_i = 1'b0;
    tick(3);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);

    // Cold miss then hit
    rst_n = 1'b1; req_i = 1'b1; addr_i = 32'h8000_0004;
    tick(); chk("cold_mreq1", 32'(mem_req_o), 32'd1);
            chk("cold_maddr1", mem_addr_o, 32'h8000_0000);
            chk("cold_ack1", 32'(ack_o), 32'd0);
    tick(); chk("cold_maddr2", mem_addr_o, 32'h8000_0004);
    tick(); chk("cold_maddr3", mem_addr_o, 32'h8000_0008);
    tick(); chk("cold_maddr4", mem_addr_o, 32'h8000_000C);
    tick(); chk("cold_mreq5", 32'(mem_req_o), 32'd0);
            chk("cold_ack5", 32'(ack_o), 32'd0);
    tick(); chk("cold_ack6", 32'(ack_o), 32'd1);
            chk("cold_rdata6", rdata_o, 32'h1001);
    addr_i = 32'h8000_000C;
    tick(); chk("hit_ack", 32'(ack_o), 32'd1);
            chk("hit_rdata", rdata_o, 32'h1003);
            chk("hit_mreq", 32'(mem_req_o), 32'd0);

    // Conflict eviction on index 0
    addr_i = 32'h8000_0400;
    tick(); chk("evict_mreq", 32'(mem_req_o), 32'd1);
            chk("evict_maddr", mem_addr_o, 32'h8000_0400);
    tick(4); chk("evict_ack5", 32'(ack_o), 32'd0);
    tick(); chk("evict_ack6", 32'(ack_o), 32'd1);
            chk("evict_rdata", rdata_o, 32'h1100);
    addr_i = 32'h8000_0000;
    tick(); chk("reevict_mreq", 32'(mem_req_o), 32'd1);
            chk("reevict_maddr", mem_addr_o, 32'h8000_0000);
            chk("reevict_ack", 32'(ack_o), 32'd0);
    tick(5); chk("reevict_ack6", 32'(ack_o), 32'd1);
             chk("reevict_rdata", rdata_o, 32'h1000);

    // Two wait cycles per word
    wait_n = 2; addr_i = 32'h8000_0010;
    tick(); chk("wait_maddr1", mem_addr_o, 32'h8000_0010);
    tick(); chk("wait_maddr2", mem_addr_o, 32'h8000_0010);
            chk("wait_mreq2", 32'(mem_req_o), 32'd1);
    tick(); chk("wait_maddr3", mem_addr_o, 32'h8000_0010);
    tick(); chk("wait_maddr4", mem_addr_o, 32'h8000_0014);
    tick(9); chk("wait_ack13", 32'(ack_o), 32'd0);
    tick(); chk("wait_ack14", 32'(ack_o), 32'd1);
            chk("wait_rdata", rdata_o, 32'h1004);
    wait_n = 0;

    // Flush in IDLE wins over a request to a cached line
    flush_i = 1'b1;
    tick(); chk("flush_ack", 32'(ack_o), 32'd0);
            chk("flush_mreq", 32'(mem_req_o), 32'd0);
    flush_i = 1'b0;
    tick(); chk("postflush_mreq", 32'(mem_req_o), 32'd1);
            chk("postflush_maddr", mem_addr_o, 32'h8000_0010);
    tick(5); chk("postflush_ack", 32'(ack_o), 32'd1);
             chk("postflush_rdata", rdata_o, 32'h1004);

    // Flush in the 2nd refill cycle leaves the filled line invalid
    addr_i = 32'h8000_0020;
    tick(2); flush_i = 1'b1;
    tick();  flush_i = 1'b0;
    tick(2); chk("rfflush_ack5", 32'(ack_o), 32'd0);
             chk("rfflush_mreq5", 32'(mem_req_o), 32'd0);
    tick();  chk("rfflush_mreq6", 32'(mem_req_o), 32'd1);
             chk("rfflush_maddr6", mem_addr_o, 32'h8000_0020);
             chk("rfflush_ack6", 32'(ack_o), 32'd0);
    tick(5); chk("rfflush_ack11", 32'(ack_o), 32'd1);
             chk("rfflush_rdata", rdata_o, 32'h1008);

    // Redirect to a cached address during a refill
    addr_i = 32'h8000_0030;
    tick(); addr_i = 32'h8000_0020;
    tick(); chk("redir_maddr2", mem_addr_o, 32'h8000_0034);
            chk("redir_mreq2", 32'(mem_req_o), 32'd1);
    tick(2); chk("redir_maddr4", mem_addr_o, 32'h8000_003C);
    tick(); chk("redir_ack5", 32'(ack_o), 32'd0);
    tick(); chk("redir_ack6", 32'(ack_o), 32'd1);
            chk("redir_rdata", rdata_o, 32'h1008);
    addr_i = 32'h8000_0030;
    tick(); chk("redir_line_ack", 32'(ack_o), 32'd1);
            chk("redir_line_rdata", rdata_o, 32'h100C);
            chk("redir_line_mreq", 32'(mem_req_o), 32'd0);

    // Reset in the 3rd refill cycle
    addr_i = 32'h8000_0040;
    tick(3); rst_n = 1'b0;
    tick();  chk("rstmid_ack", 32'(ack_o), 32'd0);
             chk("rstmid_rdata", rdata_o, 32'd0);
             chk("rstmid_mreq", 32'(mem_req_o), 32'd0);
             chk("rstmid_maddr", mem_addr_o, 32'd0);
    rst_n = 1'b1;
    tick();  chk("rstmid_miss_mreq", 32'(mem_req_o), 32'd1);
             chk("rstmid_miss_maddr", mem_addr_o, 32'h8000_0040);
             chk("rstmid_miss_ack", 32'(ack_o), 32'd0);
    tick(5); chk("rstmid_fill_ack", 32'(ack_o), 32'd1);
             chk("rstmid_fill_rdata", rdata_o, 32'h1010);
    addr_i = 32'h8000_0030;
    tick();  chk("rstmid_old_mreq", 32'(mem_req_o), 32'd1);
             chk("rstmid_old_ack", 32'(ack_o), 32'd0);
    req_i = 1'b0;
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_icache.md
# imem_icache

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction-memory request/acknowledge interface. A lookup is presented with `req`/`addr`, and a hit returns `ack`/`r_data` one cycle later. Misses stall the requester while a fixed-length line refill runs word by word over a simple request/acknowledge memory port. The block sits between the fetch stage (after MMU translation) and the instruction-side bus/memory.

## Interface
Parameters:
- `XLEN`, 32, address/data width
- `LINES`, 64, number of cache lines (power of 2)
- `WORDS_PER_LINE`, 4, 32-bit words per line (power of 2, ≥2)

Ports:
- Reset `rst_n`, synchronous, active-low; clock `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `req_i`  in  1  fetch request (from `if2imem.req`)
- `addr_i`  in  XLEN  physical fetch address (from `if2imem.addr`)
- `flush_i`  in  1  invalidate all lines (fence.i)
- `ack_o`  out  1  response valid (to `imem2if.ack`)
- `rdata_o`  out  XLEN  instruction word (to `imem2if.r_data`)
- `mem_req_o`  out  1  refill word request
- `mem_addr_o`  out  XLEN  refill word address, word aligned
- `mem_ack_i`  in  1  refill word accepted and data valid, same cycle
- `mem_rdata_i`  in  XLEN  refill word data

## Operation
- Address split:
  - offset = log2(WORDS_PER_LINE)+2 bits; `addr_i[1:0]` is ignored.
  - index = log2(LINES) bits.
  - tag = the remaining upper bits.
- Storage:
  - `valid[LINES]` and `tag[LINES]` in flops.
  - Data array `LINES*WORDS_PER_LINE` x XLEN, combinational read.
- FSM states: IDLE, REFILL.
- IDLE:
  - `flush_i`=1: clear all valid bits at the edge. The request is not serviced and `ack_o`=0 next cycle. Flush wins over `req_i`.
  - `req_i`=1, hit (valid and tag match): register the word into `rdata_o` and set `ack_o`=1 for the next cycle. Stay in IDLE, so back-to-back hits give `ack_o`=1 every cycle.
  - `req_i`=1, miss: latch tag and index, clear the word counter, move to REFILL. `ack_o`=0 next cycle.
  - `req_i`=0: `ack_o`=0 next cycle; `rdata_o` holds its last value.
- REFILL:
  - `mem_req_o`=1 with `mem_addr_o`={latched tag, index, counter, 2'b00}, held stable until `mem_ack_i`.
  - On each `mem_ack_i`: write `mem_rdata_i` to data[index][counter] and increment the counter.
  - On the last word's ack: set tag[index], set valid[index]=~flush_pend, clear all other valids if flush_pend, clear flush_pend, return to IDLE.
  - `ack_o`=0 throughout REFILL. `req_i`/`addr_i` are ignored.
  - A changed `addr_i` (redirect) does not abort the refill. The new address is looked up when IDLE resumes.
- `flush_i` during REFILL sets flush_pend, so the line being filled ends up invalid.
- Requester obligation: keep `req_i`/`addr_i` asserted until `ack_o` is seen. The fetch stage does this by holding its PC while stalled.

## Timing
- Reset values:
  - `ack_o`=0, `rdata_o`=0, `mem_req_o`=0, `mem_addr_o`=0.
  - State IDLE; all valid=0; flush_pend=0; counter=0.
- Hit latency: request in cycle C gives `ack_o`=1 with data in C+1.
- Miss latency with zero-wait memory (`mem_ack_i` high every cycle):
  - REFILL occupies C+1..C+WORDS_PER_LINE.
  - IDLE re-lookup in C+WORDS_PER_LINE+1; `ack_o` in C+WORDS_PER_LINE+2 (C+6 for defaults).
  - Each memory wait cycle adds one cycle.
- `mem_req_o` and `mem_addr_o` are registered or depend only on state/counter, never combinationally on `mem_ack_i`.
- `mem_req_o` deasserts in the cycle after the last word's ack.
- Reset asserted mid-refill:
  - The refill is abandoned and `mem_req_o`=0 from the next cycle.
  - No partial line becomes valid.
  - Any `mem_ack_i` arriving after reset is ignored.
- Index/tag arithmetic is unsigned. The counter wraps are never reached because REFILL exits at WORDS_PER_LINE-1.

## Test plan
- Cold miss then hit:
  - Stimulus: `req_i`=1, `addr_i`=0x8000_0004, memory returns 0x1000+n for word n, zero wait.
  - `mem_addr_o` sequence: 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C.
  - `ack_o`=1 with `rdata_o`=0x1001 in the 6th cycle after the request.
  - A following request to 0x8000_000C acks next cycle with 0x1003 and no `mem_req_o`.
- Conflict eviction:
  - Stimulus: fill 0x8000_0000, then request 0x8000_0400 (same index, LINES=64).
  - Required: refill occurs; re-requesting 0x8000_0000 misses again.
- Wait states: with `mem_ack_i` delayed 2 cycles per word, `mem_addr_o` is stable while waiting and `ack_o` arrives at C+14.
- Flush:
  - Flush in IDLE: the next request to a previously cached address misses.
  - `flush_i` pulsed in the 2nd REFILL cycle: after completion, the same address misses again.
- Redirect during refill: change `addr_i` to a cached address mid-refill; the refill completes, then the cached address acks in the first IDLE cycle plus 1.
- Reset mid-refill: `rst_n`=0 in the 3rd REFILL cycle; all outputs return to reset values and the line is invalid afterward.
